// File: rtl/alu16_issue.sv
// Two-stage valid/ready front-end for the alub16 combinational ALU: an operand
// register drives the ALU, a result register captures R and flags, plus sticky status.
module alu16_issue #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [3:0]       in_op,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [15:0]      alu_r,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ovfl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_r,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovfl,
  output logic             out_illegal,
  input  logic             clr_status,
  output logic             sts_ovfl,
  output logic             sts_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [15:0] a_q, b_q;
  logic [3:0]  op_q;
  logic        s1_v;
  logic        s2_adv, accept, s2_load, deliver;
  logic        dlv_ovfl, dlv_illegal;

  logic [15:0] r_nxt;
  logic        zero_nxt, neg_nxt, ovfl_nxt, illegal_nxt;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_v || s2_adv;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_v && s2_adv;
  assign deliver  = out_valid && out_ready;

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      s1_v <= 1'b0;
    end else if (accept) begin
      a_q  <= in_a;
      b_q  <= in_b;
      op_q <= in_op;
      s1_v <= 1'b1;
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end

  // The ALU's ovfl output is only meaningful for add (2) and sub (3).
  always_comb begin
    r_nxt       = '0;
    zero_nxt    = 1'b0;
    neg_nxt     = 1'b0;
    ovfl_nxt    = 1'b0;
    illegal_nxt = 1'b0;
    if (op_q[3]) begin
      illegal_nxt = 1'b1;
    end else begin
      r_nxt    = alu_r;
      zero_nxt = alu_zero;
      neg_nxt  = alu_neg;
      ovfl_nxt = ((op_q == 4'd2) || (op_q == 4'd3)) && alu_ovfl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_r       <= '0;
      out_zero    <= 1'b0;
      out_neg     <= 1'b0;
      out_ovfl    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (s2_load) begin
      out_valid   <= 1'b1;
      out_r       <= r_nxt;
      out_zero    <= zero_nxt;
      out_neg     <= neg_nxt;
      out_ovfl    <= ovfl_nxt;
      out_illegal <= illegal_nxt;
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

  assign dlv_ovfl    = deliver && out_ovfl;
  assign dlv_illegal = deliver && out_illegal;

  // A clear coinciding with a delivery wipes history but keeps the current event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts_ovfl    <= 1'b0;
      sts_illegal <= 1'b0;
      illegal_cnt <= '0;
    end else if (clr_status) begin
      sts_ovfl    <= dlv_ovfl;
      sts_illegal <= dlv_illegal;
      illegal_cnt <= dlv_illegal ? CNT_W'(1) : '0;
    end else begin
      if (dlv_ovfl)
        sts_ovfl <= 1'b1;
      if (dlv_illegal) begin
        sts_illegal <= 1'b1;
        if (illegal_cnt != {CNT_W{1'b1}})
          illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu16_issue.sv
// Directed bench for alu16_issue with a behavioural alub16 stand-in
// (0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 NAND, 6 NOR, 7 PASS A).
module tb_alu16_issue;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [15:0]      in_a, in_b;
  logic [3:0]       in_op;
  logic [15:0]      alu_a, alu_b;
  logic [3:0]       alu_op;
  logic [15:0]      alu_r;
  logic             alu_zero, alu_neg, alu_ovfl;
  logic             out_valid, out_ready;
  logic [15:0]      out_r;
  logic             out_zero, out_neg, out_ovfl, out_illegal;
  logic             clr_status;
  logic             sts_ovfl, sts_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  logic stale_ovfl;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu16_issue #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovfl(alu_ovfl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_zero(out_zero), .out_neg(out_neg),
    .out_ovfl(out_ovfl), .out_illegal(out_illegal),
    .clr_status(clr_status),
    .sts_ovfl(sts_ovfl), .sts_illegal(sts_illegal), .illegal_cnt(illegal_cnt)
  );

  // ALU stand-in; ovfl for non-arithmetic ops is driven by stale_ovfl.
  always_comb begin
    logic [15:0] s;
    s        = '0;
    alu_ovfl = stale_ovfl;
    case (alu_op[2:0])
      3'd0: s = alu_a & alu_b;
      3'd1: s = alu_a | alu_b;
      3'd2: begin
        s = alu_a + alu_b;
        alu_ovfl = (alu_a[15] == alu_b[15]) && (s[15] != alu_a[15]);
      end
      3'd3: begin
        s = alu_a - alu_b;
        alu_ovfl = (alu_a[15] != alu_b[15]) && (s[15] != alu_a[15]);
      end
      3'd4: s = alu_a ^ alu_b;
      3'd5: s = ~(alu_a & alu_b);
      3'd6: s = ~(alu_a | alu_b);
      default: s = alu_a;
    endcase
    alu_r    = s;
    alu_zero = (s == 16'h0);
    alu_neg  = s[15];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    out_ready = 1'b0;
    clr_status = 1'b0;
    stale_ovfl = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    repeat (2) step();

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_sts", {sts_ovfl, sts_illegal, illegal_cnt}, 0);
    rst_n = 1'b1;

    // add overflow
    out_ready = 1'b1;
    drive(1'b1, 16'h7FFF, 16'h0001, 4'd2);
    chk("add_in_ready", in_ready, 1);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    chk("add_alu_a", alu_a, 16'h7FFF);
    chk("add_not_yet", out_valid, 0);
    step();
    chk("add_valid", out_valid, 1);
    chk("add_r", out_r, 16'h8000);
    chk("add_flags", {out_zero, out_neg, out_ovfl, out_illegal}, 4'b0110);
    chk("add_sts_pre", sts_ovfl, 0);
    step();
    chk("add_sts_ovfl", sts_ovfl, 1);
    chk("add_drained", out_valid, 0);

    // sub then AND back-to-back, stale ovfl high from the ALU
    stale_ovfl = 1'b1;
    drive(1'b1, 16'd5, 16'd5, 4'd3);
    step();
    drive(1'b1, 16'h00F0, 16'h0F00, 4'd0);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    chk("sub_r", out_r, 0);
    chk("sub_flags", {out_valid, out_zero, out_neg, out_ovfl}, 4'b1100);
    step();
    chk("and_r", out_r, 0);
    chk("and_flags", {out_valid, out_zero, out_neg, out_ovfl}, 4'b1100);
    step();
    chk("and_drained", out_valid, 0);
    stale_ovfl = 1'b0;

    // clear with no delivery
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("clr_sts_ovfl", sts_ovfl, 0);

    // back-pressure: three requests, only two accepted
    out_ready = 1'b0;
    drive(1'b1, 16'hFFFF, 16'h00FF, 4'd4);
    step();
    drive(1'b1, 16'h1200, 16'h0034, 4'd1);
    chk("bp_ready2", in_ready, 1);
    step();
    drive(1'b1, 16'hFF00, 16'h0F0F, 4'd5);
    chk("bp_ready3", in_ready, 0);
    step();
    chk("bp_hold_r", out_r, 16'hFF00);
    chk("bp_hold_ready", in_ready, 0);
    step();
    chk("bp_hold_r2", {out_valid, out_r, out_neg}, {1'b1, 16'hFF00, 1'b1});
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    chk("bp_or", {out_valid, out_r, out_neg}, {1'b1, 16'h1234, 1'b0});
    step();
    chk("bp_nand", {out_valid, out_r, out_neg}, {1'b1, 16'hF0FF, 1'b1});
    step();
    chk("bp_drained", out_valid, 0);

    // illegal ops and counter saturation
    drive(1'b1, 16'h1234, 16'h0001, 4'd9);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    step();
    chk("ill_out", {out_valid, out_r, out_zero, out_neg, out_ovfl, out_illegal},
        {1'b1, 16'h0, 4'b0001});
    step();
    chk("ill_cnt1", illegal_cnt, 1);
    chk("ill_sts", sts_illegal, 1);
    drive(1'b1, 16'h1234, 16'h0001, 4'd15);
    for (int i = 0; i < 255; i++) step();
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    chk("ill_cnt_fe", illegal_cnt, 8'hFE);
    step();
    chk("ill_cnt_ff", illegal_cnt, 8'hFF);
    step();
    chk("ill_cnt_sat", illegal_cnt, 8'hFF);
    step();
    chk("ill_drained", out_valid, 0);

    // clear coinciding with delivery of an illegal op
    drive(1'b1, 16'h7FFF, 16'h0001, 4'd2);
    step();
    drive(1'b1, 16'h0, 16'h0, 4'd8);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    step();
    chk("clrd_pre", {out_valid, out_illegal, sts_ovfl}, 3'b111);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("clrd_sts", {sts_ovfl, sts_illegal}, 2'b01);
    chk("clrd_cnt", illegal_cnt, 1);

    // reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, 16'h0010, 16'h0020, 4'd2);
    step();
    drive(1'b1, 16'hAAAA, 16'h5555, 4'd4);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    chk("full_ready", {in_ready, out_valid, out_r}, {2'b01, 16'h0030});
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {out_valid, in_ready}, 2'b01);
    chk("mid_rst_out", {out_r, out_zero, out_neg, out_ovfl, out_illegal}, 0);
    chk("mid_rst_alu", {alu_a, alu_op}, 0);
    chk("mid_rst_sts", {sts_ovfl, sts_illegal, illegal_cnt}, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("no_stale", seen, 0);

    drive(1'b1, 16'd3, 16'd5, 4'd3);
    step();
    drive(1'b0, 16'h0, 16'h0, 4'h0);
    seen = 0;
    for (int i = 0; i < 4 && !out_valid; i++) begin
      step();
      seen++;
    end
    chk("post_rst_latency", {out_valid, 8'(seen)}, {1'b1, 8'd1});
    chk("post_rst_r", {out_r, out_neg, out_ovfl}, {16'hFFFE, 2'b10});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu16_issue.md
# alu16_issue

Pipelined request/response front-end for the 16-bit combinational ALU (`alub16`). It accepts operations from the control path over a valid/ready handshake, registers the operands and drives the ALU's `A`/`B`/`op` inputs. It then captures `R` and the flags into an output register with its own valid/ready handshake. It also keeps sticky status flags and counts illegal opcodes, so the control path never samples the ALU combinationally.

## Interface
Parameters:
- `CNT_W`, default 8: width of the illegal-op counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request can be accepted this cycle.
- `in_a`, `in_b`  in  16 each  signed operands.
- `in_op`  in  4  ALU opcode.
- `alu_a`, `alu_b`  out  16 each  to ALU `A`, `B`.
- `alu_op`  out  4  to ALU `op`.
- `alu_r`  in  16  from ALU `R`.
- `alu_zero`, `alu_neg`, `alu_ovfl`  in  1 each  from ALU `isZero`, `isNegative`, `ovfl`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_r`  out  16  result.
- `out_zero`, `out_neg`, `out_ovfl`, `out_illegal`  out  1 each  result flags.
- `clr_status`  in  1  synchronous clear of sticky status and counter.
- `sts_ovfl`  out  1  sticky: some delivered result had `out_ovfl=1`.
- `sts_illegal`  out  1  sticky: some delivered result had `out_illegal=1`.
- `illegal_cnt`  out  `CNT_W`  saturating count of delivered illegal ops.

## Operation
- Two stages:
  - S1: operand register (`a_q`, `b_q`, `op_q`, `s1_v`).
  - S2: result register (`out_*`, `out_valid`).
- `alu_a=a_q`, `alu_b=b_q`, `alu_op=op_q`, driven straight from the S1 registers.
- Advance conditions:
  - `s2_adv = !out_valid || out_ready`.
  - `in_ready = !s1_v || s2_adv`. This is combinational and does not depend on `in_valid`.
- Accept: `in_valid && in_ready` loads S1 and sets `s1_v=1`. If there is no accept while S1 drains into S2, `s1_v` goes to 0.
- S2 load when `s1_v && s2_adv`. Values loaded into S2:
  - Legal op (0–7): `out_r=alu_r`, `out_zero=alu_zero`, `out_neg=alu_neg`, `out_illegal=0`.
  - `out_ovfl=alu_ovfl` only for op 2 (add) and op 3 (sub); forced 0 for every other op. The ALU's `ovfl` output is stale for other ops and must be masked.
  - Illegal op (8–15): `out_r=0`, `out_zero=0`, `out_neg=0`, `out_ovfl=0`, `out_illegal=1`.
- S2 drain: if `out_valid && out_ready` and S1 is empty, `out_valid` goes to 0. While `out_valid=1 && !out_ready`, all `out_*` are held stable.
- Delivery event = `out_valid && out_ready`. On delivery:
  - `sts_ovfl |= out_ovfl`.
  - `sts_illegal |= out_illegal`.
  - `illegal_cnt` increments if `out_illegal=1`, saturating at all-ones.
- `clr_status` in the same cycle as a delivery: the clear zeroes the old value and the current event still applies. Result is `sts = event`, `cnt = event ? 1 : 0`.
- Reset: `s1_v=0`, `out_valid=0`, and all `out_*`, `a_q`, `b_q`, `op_q`, `sts_*` and `illegal_cnt` are 0. Consequently `in_ready=1` and `alu_op=0` out of reset.
- Reset mid-operation discards in-flight requests; no result for them is ever produced.

## Timing
- Latency: a request accepted at edge N appears with `out_valid=1` after edge N+1, provided S2 is free.
- Throughput: one op per cycle with `out_ready` held at 1.
- Full pipeline: with `out_valid=1`, `out_ready=0` and `s1_v=1`, `in_ready=0`. Two requests are buffered.
- Full pipeline, `out_ready` rises: in that cycle `in_ready=1`, and a simultaneous accept, S1→S2 transfer and delivery all occur on one edge.
- ALU path: `a_q` → ALU → S2 must fit in one clock period. No combinational path runs from `in_*` to `alu_*`.

## Test plan
- Add, `in_a=0x7FFF`, `in_b=0x0001`, `op=2`, `out_ready=1` -> two cycles later: `out_r=0x8000`, `out_neg=1`, `out_ovfl=1`, `out_zero=0`; `sts_ovfl=1` after delivery.
- Sub 5−5 (`op=3`), then AND `0x00F0 & 0x0F00` (`op=0`) back-to-back -> `out_r=0x0000`, `out_zero=1` on both. `out_ovfl=0` on the AND, even if the ALU's `ovfl` is still high.
- Back-pressure: hold `out_ready=0` and issue 3 requests -> `in_ready` drops after 2 accepts; `out_r` is held. Release -> results arrive in order (XOR `0xFFFF^0x00FF=0xFF00`, `out_neg=1`; OR; NAND), one per cycle, none lost or duplicated.
- Illegal: `op=9` -> `out_r=0`, `out_illegal=1`, `illegal_cnt=1`. 255 more illegal ops -> count stays at `0xFF` (`CNT_W=8`).
- `clr_status` asserted in the same cycle as delivery of an illegal op -> next cycle `sts_illegal=1`, `illegal_cnt=1`, `sts_ovfl=0`.
- Assert `rst_n=0` while both stages are full -> immediately `out_valid=0`, `in_ready=1`, and all outputs 0. After release, no stale result is ever emitted.
